// File: rtl/inst_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_encoder_pkg
// Description : RV32I immediate-format selectors, opcodes and range helper
// Revision    : 1.0 - initial release
// ============================================================================
package inst_encoder_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100,
        IMM_R = 3'b101
    } imm_sel_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // True when value[31:sign_lsb] is a pure sign extension (all zeros or all ones).
    function automatic logic imm_fits(input logic [31:0] value, input logic [4:0] sign_lsb);
        logic [31:0] w_shifted;
        w_shifted = 32'($signed(value) >>> sign_lsb);
        return (w_shifted == '0) || (w_shifted == '1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_pack.sv
`default_nettype none
// ============================================================================
// Module      : inst_pack
// Description : Combinational RV32I field packer with immediate range check
// Revision    : 1.0 - initial release
// ============================================================================
module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [2:0]  i_imm_sel,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_inst,
    output logic        o_err
);

    always_comb begin
        o_inst = '0;
        o_err  = 1'b0;
        case (i_imm_sel)
            IMM_I: begin
                o_inst = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                o_err  = !imm_fits(i_imm, 5'd11);
            end
            IMM_S: begin
                o_inst = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                o_err  = !imm_fits(i_imm, 5'd11);
            end
            IMM_B: begin
                o_inst = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                          i_imm[4:1], i_imm[11], i_opcode};
                o_err  = !imm_fits(i_imm, 5'd12) || i_imm[0];
            end
            IMM_J: begin
                o_inst = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                o_err  = !imm_fits(i_imm, 5'd20) || i_imm[0];
            end
            IMM_U: begin
                o_inst = {i_imm[31:12], i_rd, i_opcode};
                o_err  = (i_imm[11:0] != 12'd0);
            end
            IMM_R: begin
                o_inst = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
                o_err  = 1'b0;
            end
            default: begin
                // Unknown format: emit a null word so nothing decodable leaks out.
                o_inst = '0;
                o_err  = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : inst_encoder
// Description : Valid/ready RV32I instruction encoder with 2-entry skid buffer
// Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ImmSel,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      inst,
    output logic             err,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      w_pack_inst;
    logic             w_pack_err;
    logic             w_in_fire;
    logic             w_out_fire;

    logic             r_in_ready;
    logic             r_out_valid;
    logic [31:0]      r_inst;
    logic             r_err;
    logic             r_skid_valid;
    logic [31:0]      r_skid_inst;
    logic             r_skid_err;
    logic [CNT_W-1:0] r_enc_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    inst_pack u_pack (
        .i_imm_sel (ImmSel),
        .i_opcode  (opcode),
        .i_rd      (rd),
        .i_rs1     (rs1),
        .i_rs2     (rs2),
        .i_funct3  (funct3),
        .i_funct7  (funct7),
        .i_imm     (imm),
        .o_inst    (w_pack_inst),
        .o_err     (w_pack_err)
    );

    assign w_in_fire  = in_valid && r_in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    // r_in_ready is kept as its own flop, always equal to the inverse of r_skid_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_inst       <= '0;
            r_err        <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_inst  <= '0;
            r_skid_err   <= 1'b0;
        end else if (r_skid_valid) begin
            if (w_out_fire) begin
                r_inst       <= r_skid_inst;
                r_err        <= r_skid_err;
                r_skid_valid <= 1'b0;
                r_in_ready   <= 1'b1;
            end
        end else if (w_in_fire) begin
            if (!r_out_valid || w_out_fire) begin
                r_out_valid <= 1'b1;
                r_inst      <= w_pack_inst;
                r_err       <= w_pack_err;
            end else begin
                r_skid_valid <= 1'b1;
                r_skid_inst  <= w_pack_inst;
                r_skid_err   <= w_pack_err;
                r_in_ready   <= 1'b0;
            end
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_enc_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_out_fire) begin
            if (r_enc_cnt != '1) begin
                r_enc_cnt <= r_enc_cnt + c_cnt_one;
            end
            if (r_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + c_cnt_one;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign inst      = r_inst;
    assign err       = r_err;
    assign enc_cnt   = r_enc_cnt;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire
